// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a JK flip-flop: queues hold/reset/set/toggle commands, replays each on
// registered j/k for a programmable length, and checks the flip-flop feedback against a local model.
module jk_cmd_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 1,
    parameter int unsigned LEN_W = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [1:0]                 cmd_i,
    input  logic [LEN_W-1:0]           cmd_len_i,
    output logic                       j_out_o,
    output logic                       k_out_o,
    output logic                       ff_reset_o,
    input  logic                       q_fb_i,
    input  logic                       qn_fb_i,
    output logic                       exp_q_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       err_o,
    input  logic                       err_clr_i
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned ENT_W  = 2 + LEN_W;
    localparam int unsigned GCNT_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP
    } state_t;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              push_c, pop_c, fifo_ne_c;
    logic [1:0]        head_cmd_c;
    logic [LEN_W-1:0]  head_len_c;

    state_t            state_q, state_d;
    logic [1:0]        jk_q, jk_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic              try_load_c;

    logic              ff_reset_q, exp_q_q, chk_en_q, err_q, mismatch_c;

    assign fifo_ne_c   = (level_q != '0);
    assign cmd_ready_o = !reset_i && !ff_reset_q && (level_q < LVL_W'(DEPTH));
    assign push_c      = cmd_valid_i && cmd_ready_o;
    assign head_cmd_c  = mem_q[rd_ptr_q][ENT_W-1 -: 2];
    assign head_len_c  = mem_q[rd_ptr_q][LEN_W-1:0];

    // FIFO storage carries no reset; only pointers and occupancy are cleared.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {cmd_i, cmd_len_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Next-state logic; any state that finishes its work falls into a load attempt on the same edge.
    always_comb begin
        state_d    = state_q;
        jk_d       = jk_q;
        cnt_d      = cnt_q;
        gcnt_d     = gcnt_q;
        pop_c      = 1'b0;
        try_load_c = 1'b0;
        case (state_q)
            S_IDLE: try_load_c = 1'b1;
            S_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else if (GAP != 0) begin
                    jk_d    = 2'b00;
                    gcnt_d  = GCNT_W'(GAP - 1);
                    state_d = S_GAP;
                end else begin
                    try_load_c = 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt_q != '0) gcnt_d = gcnt_q - GCNT_W'(1);
                else              try_load_c = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (try_load_c) begin
            if (fifo_ne_c) begin
                pop_c   = 1'b1;
                jk_d    = head_cmd_c;
                cnt_d   = (head_len_c == '0) ? '0 : head_len_c - LEN_W'(1);
                state_d = S_DRIVE;
            end else begin
                jk_d    = 2'b00;
                state_d = S_IDLE;
            end
        end
    end

    assign mismatch_c = (q_fb_i != exp_q_q) || (qn_fb_i != !q_fb_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            jk_q       <= 2'b00;
            cnt_q      <= '0;
            gcnt_q     <= '0;
            ff_reset_q <= 1'b1;
            exp_q_q    <= 1'b0;
            chk_en_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            jk_q       <= jk_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
            ff_reset_q <= 1'b0;
            chk_en_q   <= !ff_reset_q;
            if (ff_reset_q) begin
                exp_q_q <= 1'b0;
            end else begin
                case (jk_q)
                    2'b01:   exp_q_q <= 1'b0;
                    2'b10:   exp_q_q <= 1'b1;
                    2'b11:   exp_q_q <= !exp_q_q;
                    default: exp_q_q <= exp_q_q;
                endcase
            end
            // Clear has priority over a mismatch seen on the same edge.
            if (err_clr_i)                    err_q <= 1'b0;
            else if (chk_en_q && mismatch_c)  err_q <= 1'b1;
        end
    end

    assign j_out_o    = jk_q[1];
    assign k_out_o    = jk_q[0];
    assign ff_reset_o = ff_reset_q;
    assign exp_q_o    = exp_q_q;
    assign err_o      = err_q;
    assign level_o    = level_q;
    assign busy_o     = (state_q != S_IDLE) || fifo_ne_c;

endmodule
